// File: rtl/dsp_op_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_op_sequencer
//
// Initiator-side controller for one fracturable DSP multiply-accumulate slice.
// Accepts one operation request at a time on a valid/ready port. It latches the
// request fields onto the DSP operand pins and fires a single start pulse. It
// then checks that the DSP completion strobe arrives exactly at the
// mode-specific latency. The captured result (or an error) is returned on a
// valid/ready response port.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_mode, req_mac,         request fields: mode (00 half/half, 01 half/full,
//   req_shift, req_a,          10 full/full, 11 illegal), accumulate enable,
//   req_b, req_c               accumulator shift, operands A/B, addend C
//   dsp_start                  one-cycle start pulse to the DSP
//   dsp_mode .. dsp_cc         latched request fields driven to the DSP
//   dsp_out, dsp_done          DSP result and completion strobe
//   rsp_valid / rsp_ready      response handshake
//   rsp_data, rsp_err          captured result, error flag
//   proto_err                  sticky: completion strobe seen while not busy
// -----------------------------------------------------------------------------
module dsp_op_sequencer #(
    parameter int N = 9,
    parameter int M = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_mode,
    input  logic             req_mac,
    input  logic [1:0]       req_shift,
    input  logic [N-1:0]     req_a,
    input  logic [M-1:0]     req_b,
    input  logic [N+M-1:0]   req_c,
    output logic             dsp_start,
    output logic [1:0]       dsp_mode,
    output logic             dsp_mac,
    output logic [1:0]       dsp_shift,
    output logic [N-1:0]     dsp_aa,
    output logic [M-1:0]     dsp_bb,
    output logic [N+M-1:0]   dsp_cc,
    input  logic [N+M-1:0]   dsp_out,
    input  logic             dsp_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N+M-1:0]   rsp_data,
    output logic             rsp_err,
    output logic             proto_err
);

    localparam int W = N + M;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Cycles from the start cycle to the expected completion strobe.
    function automatic logic [2:0] exp_latency(input logic [1:0] mode);
        logic [2:0] lat;
        case (mode)
            2'b00:   lat = 3'd0;
            2'b01:   lat = 3'd1;
            2'b10:   lat = 3'd3;
            default: lat = 3'd0;
        endcase
        return lat;
    endfunction

    state_t         state_r, state_nxt_s;
    logic [2:0]     cnt_r, cnt_nxt_s;
    logic           ready_r, ready_nxt_s;
    logic           start_r, start_nxt_s;
    logic           rsp_valid_r, rsp_valid_nxt_s;
    logic [W-1:0]   rsp_data_r, rsp_data_nxt_s;
    logic           rsp_err_r, rsp_err_nxt_s;
    logic           proto_err_r, proto_err_nxt_s;
    logic [1:0]     mode_r;
    logic           mac_r;
    logic [1:0]     shift_r;
    logic [N-1:0]   aa_r;
    logic [M-1:0]   bb_r;
    logic [W-1:0]   cc_r;
    logic           accept_s;
    logic [2:0]     lat_s;

    // The latched mode decides the latency for the operation in flight.
    assign lat_s    = exp_latency(mode_r);
    assign accept_s = (state_r == ST_IDLE) && req_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    // An illegal mode is answered directly, without touching the DSP.
                    state_nxt_s = (req_mode == 2'b11) ? ST_RESP : ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // Zero-latency modes must complete in the start cycle. A strobe in
                // the start cycle of a longer mode is an error. Both cases end here.
                if ((lat_s == 3'd0) || dsp_done) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dsp_done || (cnt_r == lat_s)) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values for the counter and all registered outputs.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        start_nxt_s     = (state_nxt_s == ST_ISSUE);
        rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
        ready_nxt_s     = (state_nxt_s == ST_IDLE);
        // A strobe while nothing is in flight means the DSP and sequencer disagree.
        proto_err_nxt_s = proto_err_r |
                          (dsp_done && ((state_r == ST_IDLE) || (state_r == ST_RESP)));
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 3'd0;
                if (accept_s && (req_mode == 2'b11)) begin
                    rsp_data_nxt_s = {W{1'b0}};
                    rsp_err_nxt_s  = 1'b1;
                end else begin
                    rsp_data_nxt_s = rsp_data_r;
                    rsp_err_nxt_s  = rsp_err_r;
                end
            end
            ST_ISSUE: begin
                cnt_nxt_s = 3'd1;
                if ((lat_s == 3'd0) && dsp_done) begin
                    rsp_data_nxt_s = dsp_out;
                    rsp_err_nxt_s  = 1'b0;
                end else if ((lat_s == 3'd0) || dsp_done) begin
                    rsp_data_nxt_s = {W{1'b0}};
                    rsp_err_nxt_s  = 1'b1;
                end else begin
                    rsp_data_nxt_s = rsp_data_r;
                    rsp_err_nxt_s  = rsp_err_r;
                end
            end
            ST_WAIT: begin
                if (dsp_done && (cnt_r == lat_s)) begin
                    rsp_data_nxt_s = dsp_out;
                    rsp_err_nxt_s  = 1'b0;
                end else if (dsp_done || (cnt_r == lat_s)) begin
                    // Early strobe or timeout.
                    rsp_data_nxt_s = {W{1'b0}};
                    rsp_err_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 3'd1;
                end
            end
            ST_RESP: begin
                cnt_nxt_s = cnt_r;
            end
            default: begin
                cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // Output, counter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= 3'd0;
            ready_r     <= 1'b1;
            start_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {W{1'b0}};
            rsp_err_r   <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            ready_r     <= ready_nxt_s;
            start_r     <= start_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            proto_err_r <= proto_err_nxt_s;
        end
    end

    // Request field latch; the DSP pins stay put until the next accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r  <= 2'b00;
            mac_r   <= 1'b0;
            shift_r <= 2'b00;
            aa_r    <= {N{1'b0}};
            bb_r    <= {M{1'b0}};
            cc_r    <= {W{1'b0}};
        end else if (accept_s) begin
            mode_r  <= req_mode;
            mac_r   <= req_mac;
            shift_r <= req_shift;
            aa_r    <= req_a;
            bb_r    <= req_b;
            cc_r    <= req_c;
        end else begin
            mode_r  <= mode_r;
            mac_r   <= mac_r;
            shift_r <= shift_r;
            aa_r    <= aa_r;
            bb_r    <= bb_r;
            cc_r    <= cc_r;
        end
    end

    assign req_ready = ready_r;
    assign dsp_start = start_r;
    assign dsp_mode  = mode_r;
    assign dsp_mac   = mac_r;
    assign dsp_shift = shift_r;
    assign dsp_aa    = aa_r;
    assign dsp_bb    = bb_r;
    assign dsp_cc    = cc_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dsp_op_sequencer
//
// Directed bench for dsp_op_sequencer. A small behavioural DSP supplies the
// result and a completion strobe at the nominal latency. Individual tests can
// take over the strobe to inject early, missing or stray completions.
// -----------------------------------------------------------------------------
module tb_dsp_op_sequencer;

    localparam int N = 9;
    localparam int M = 9;
    localparam int W = N + M;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_mode = 2'b00;
    logic           req_mac = 1'b0;
    logic [1:0]     req_shift = 2'b00;
    logic [N-1:0]   req_a = '0;
    logic [M-1:0]   req_b = '0;
    logic [W-1:0]   req_c = '0;
    logic           dsp_start;
    logic [1:0]     dsp_mode;
    logic           dsp_mac;
    logic [1:0]     dsp_shift;
    logic [N-1:0]   dsp_aa;
    logic [M-1:0]   dsp_bb;
    logic [W-1:0]   dsp_cc;
    logic [W-1:0]   dsp_out;
    logic           dsp_done;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           proto_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int start_seen = 0;

    always #5 clk = ~clk;

    dsp_op_sequencer #(.N(N), .M(M)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_mac(req_mac), .req_shift(req_shift),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .dsp_start(dsp_start), .dsp_mode(dsp_mode), .dsp_mac(dsp_mac),
        .dsp_shift(dsp_shift), .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc),
        .dsp_out(dsp_out), .dsp_done(dsp_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .proto_err(proto_err)
    );

    // ---------------- behavioural DSP ----------------
    logic signed [W-1:0] pa, pb, addend;
    logic [W-1:0]        acc_q = '0;
    logic [2:0]          age = 3'd0;
    logic                active = 1'b0;
    logic [2:0]          lat_b;
    logic                auto_done;
    logic                done_auto_en = 1'b1;
    logic                done_force = 1'b0;

    always_comb begin
        if (dsp_mode == 2'b00) begin
            pa = {{(W-5){dsp_aa[4]}}, dsp_aa[4:0]};
            pb = {{(W-5){dsp_bb[4]}}, dsp_bb[4:0]};
        end else if (dsp_mode == 2'b01) begin
            pa = {{(W-5){dsp_aa[4]}}, dsp_aa[4:0]};
            pb = {{(W-M){dsp_bb[M-1]}}, dsp_bb};
        end else begin
            pa = {{(W-N){dsp_aa[N-1]}}, dsp_aa};
            pb = {{(W-M){dsp_bb[M-1]}}, dsp_bb};
        end
        addend = dsp_mac ? (acc_q <<< dsp_shift) : dsp_cc;
        lat_b  = (dsp_mode == 2'b01) ? 3'd1 : ((dsp_mode == 2'b10) ? 3'd3 : 3'd0);
    end

    assign dsp_out   = pa * pb + addend;
    assign auto_done = (dsp_start && (lat_b == 3'd0)) ||
                       (active && (lat_b != 3'd0) && (age == lat_b));
    assign dsp_done  = done_auto_en ? auto_done : done_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            age    <= 3'd0;
        end else if (dsp_start) begin
            active <= 1'b1;
            age    <= 3'd1;
        end else if (active) begin
            if (age >= lat_b) active <= 1'b0;
            age <= age + 3'd1;
        end
    end

    always @(posedge clk) begin
        if (dsp_done) acc_q <= dsp_out;
        if (dsp_start) start_seen <= start_seen + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in IDLE; returns in cycle T+1 (accept edge T).
    task automatic send_req(input logic [1:0] m, input logic [N-1:0] a,
                            input logic [M-1:0] b, input logic [W-1:0] c);
        req_mode  = m;
        req_a     = a;
        req_b     = b;
        req_c     = c;
        req_mac   = 1'b0;
        req_shift = 2'b00;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if ({rsp_valid, dsp_start, rsp_err, proto_err} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {rsp_valid, dsp_start, rsp_err, proto_err});
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 18'd0 || dsp_cc !== 18'd0 || dsp_aa !== 9'd0) $display("FAIL reset_data: got rsp_data=%h dsp_cc=%h dsp_aa=%h expected 0", rsp_data, dsp_cc, dsp_aa);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_mode00();
        int s0;
        s0 = start_seen;
        send_req(2'b00, 9'd3, 9'h1FE, 18'd10);
        total_cnt++;
        if (dsp_start !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) $display("FAIL m00_issue: got start=%b valid=%b ready=%b expected 1 0 0", dsp_start, rsp_valid, req_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 18'd4 || rsp_err !== 1'b0) $display("FAIL m00_resp: got valid=%b data=%h err=%b expected 1 00004 0", rsp_valid, rsp_data, rsp_err);
        else pass_cnt++;
        total_cnt++;
        if (dsp_start !== 1'b0) $display("FAIL m00_start_drop: got %b expected 0", dsp_start);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (start_seen - s0 !== 1 || req_ready !== 1'b1) $display("FAIL m00_one_start: got starts=%0d ready=%b expected 1 1", start_seen - s0, req_ready);
        else pass_cnt++;
    endtask

    task automatic test_mode10();
        logic stable_ok;
        stable_ok = 1'b1;
        send_req(2'b10, 9'd100, 9'h1FD, 18'd0);
        for (int k = 1; k <= 4; k++) begin
            if (dsp_aa !== 9'd100 || dsp_bb !== 9'h1FD || rsp_valid !== 1'b0) stable_ok = 1'b0;
            tick();
        end
        total_cnt++;
        if (stable_ok !== 1'b1) $display("FAIL m10_stable: got %b expected 1", stable_ok);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 18'h3FED4 || rsp_err !== 1'b0) $display("FAIL m10_resp: got valid=%b data=%h err=%b expected 1 3fed4 0", rsp_valid, rsp_data, rsp_err);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_mode11();
        int s0;
        s0 = start_seen;
        send_req(2'b11, 9'd1, 9'd1, 18'd1);
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 18'd0 || dsp_start !== 1'b0) $display("FAIL m11_resp: got valid=%b err=%b data=%h start=%b expected 1 1 0 0", rsp_valid, rsp_err, rsp_data, dsp_start);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (start_seen - s0 !== 0 || req_ready !== 1'b1) $display("FAIL m11_nostart: got starts=%0d ready=%b expected 0 1", start_seen - s0, req_ready);
        else pass_cnt++;
    endtask

    task automatic test_latency_errors();
        int cyc;
        done_auto_en = 1'b0;
        done_force   = 1'b0;
        send_req(2'b10, 9'd7, 9'd7, 18'd0);
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        total_cnt++;
        if (cyc !== 5 || rsp_err !== 1'b1 || rsp_data !== 18'd0) $display("FAIL timeout: got cycle=%0d err=%b data=%h expected 5 1 0", cyc, rsp_err, rsp_data);
        else pass_cnt++;
        tick();
        send_req(2'b10, 9'd7, 9'd7, 18'd0);
        tick();
        done_force = 1'b1;
        tick();
        done_force = 1'b0;
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 18'd0) $display("FAIL early_done: got valid=%b err=%b data=%h expected 1 1 0", rsp_valid, rsp_err, rsp_data);
        else pass_cnt++;
        tick();
        done_auto_en = 1'b1;
        total_cnt++;
        if (proto_err !== 1'b0) $display("FAIL proto_quiet: got %b expected 0", proto_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int accepts;
        int first_idx;
        int second_idx;
        int guard;
        logic data_ok;
        accepts = 0;
        first_idx = -1;
        second_idx = -1;
        data_ok = 1'b1;
        rsp_ready = 1'b1;
        req_mode = 2'b00; req_a = 9'd3; req_b = 9'h1FE; req_c = 18'd10;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (req_ready === 1'b1) begin
                if (accepts == 0) first_idx = i;
                if (accepts == 1) second_idx = i;
                accepts++;
            end
            if (rsp_valid === 1'b1 && rsp_data !== 18'd4) data_ok = 1'b0;
            tick();
        end
        req_valid = 1'b0;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        total_cnt++;
        if (accepts !== 4 || second_idx - first_idx !== 3) $display("FAIL b2b_spacing: got accepts=%0d gap=%0d expected 4 3", accepts, second_idx - first_idx);
        else pass_cnt++;
        total_cnt++;
        if (data_ok !== 1'b1 || guard >= 20) $display("FAIL b2b_data: got data_ok=%b drain=%0d expected 1 <20", data_ok, guard);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic hold_ok;
        hold_ok = 1'b1;
        rsp_ready = 1'b0;
        send_req(2'b01, 9'd5, 9'd7, 18'd1);
        tick();
        tick();
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== 18'd36 || rsp_err !== 1'b0) $display("FAIL m01_resp: got valid=%b data=%h err=%b expected 1 00024 0", rsp_valid, rsp_data, rsp_err);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== 18'd36 || rsp_err !== 1'b0 || req_ready !== 1'b0) hold_ok = 1'b0;
        end
        total_cnt++;
        if (hold_ok !== 1'b1) $display("FAIL bp_hold: got %b expected 1", hold_ok);
        else pass_cnt++;
        rsp_ready = 1'b1;
        tick();
        total_cnt++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL bp_release: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
        else pass_cnt++;
        done_auto_en = 1'b0;
        done_force = 1'b1;
        tick();
        done_force = 1'b0;
        total_cnt++;
        if (proto_err !== 1'b1) $display("FAIL proto_set: got %b expected 1", proto_err);
        else pass_cnt++;
        tick();
        tick();
        tick();
        total_cnt++;
        if (proto_err !== 1'b1) $display("FAIL proto_sticky: got %b expected 1", proto_err);
        else pass_cnt++;
        done_auto_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic no_rsp;
        no_rsp = 1'b1;
        send_req(2'b10, 9'd100, 9'h1FD, 18'd0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (rsp_valid !== 1'b0 || dsp_start !== 1'b0 || dsp_aa !== 9'd0 || proto_err !== 1'b0) $display("FAIL rst_mid: got valid=%b start=%b aa=%h proto=%b expected 0 0 0 0", rsp_valid, dsp_start, dsp_aa, proto_err);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid !== 1'b0) no_rsp = 1'b0;
        end
        total_cnt++;
        if (no_rsp !== 1'b1 || req_ready !== 1'b1) $display("FAIL rst_no_rsp: got no_rsp=%b ready=%b expected 1 1", no_rsp, req_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mode00();
        test_mode10();
        test_mode11();
        test_latency_errors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/dsp_op_sequencer.md
# dsp_op_sequencer

Initiator-side controller for the fracturable DSP multiply-accumulate slice. Accepts full operation requests on a valid/ready port and drives the DSP's `start`/`mode`/operand pins with a single start pulse. It holds the operands stable, then waits the mode-specific latency for the DSP's `compare_res` completion strobe and captures the result. The result goes back on a valid/ready response port, with protocol errors flagged. It sits between the operand scheduler and one DSP instance.

## Interface
- `N`, 9, multiplicand width (matches DSP `N`)
- `M`, 9, multiplier width (matches DSP `M`)
- `clk  in  1  rising-edge clock`
- `rst_n  in  1  reset, asynchronous, active-low`
- `req_valid  in  1  request present`
- `req_ready  out  1  sequencer can accept (IDLE only)`
- `req_mode  in  2  00 half/half, 01 half/full 2-cycle, 10 full/full 4-cycle, 11 illegal`
- `req_mac  in  1  accumulate into DSP's previous result instead of adding req_c`
- `req_shift  in  2  barrel shift applied to accumulator when req_mac=1`
- `req_a  in  N  operand A`
- `req_b  in  M  operand B`
- `req_c  in  N+M  addend`
- `dsp_start  out  1  one-cycle start pulse to DSP`
- `dsp_mode, dsp_mac, dsp_shift, dsp_aa, dsp_bb, dsp_cc  out  2/1/2/N/M/N+M  latched request fields to DSP`
- `dsp_out  in  N+M  DSP result`
- `dsp_done  in  1  DSP `compare_res``
- `rsp_valid  out  1  response present`
- `rsp_ready  in  1  consumer accepts response`
- `rsp_data  out  N+M  captured result (signed)`
- `rsp_err  out  1  response carries error (illegal mode or latency mismatch)`
- `proto_err  out  1  sticky: dsp_done seen outside ISSUE/WAIT; cleared only by reset`

## Operation
- Expected latency L(mode) from start cycle to done: 00→0, 01→1, 10→3.
- States: IDLE, ISSUE, WAIT, RESP. 3-bit counter `cnt`.
- IDLE: req_ready=1. On req_valid: latch all req_* fields into dsp_* registers. mode≠11 → ISSUE. mode=11 → RESP with rsp_err=1, rsp_data=0, no start issued.
- ISSUE: dsp_start=1 for exactly this cycle; cnt=0.
  - If L=0 and dsp_done=1: capture dsp_out → RESP, err=0.
  - If L=0 and dsp_done=0: → RESP with err=1, rsp_data=0.
  - Otherwise (L>0): dsp_done=1 → RESP with err=1, rsp_data=0; dsp_done=0 → WAIT, cnt=1.
- WAIT: dsp_start=0, dsp_* fields held unchanged.
  - dsp_done && cnt==L → capture dsp_out, RESP, err=0.
  - dsp_done && cnt<L → RESP, err=1.
  - !dsp_done && cnt==L → RESP, err=1 (timeout).
  - Otherwise cnt++.
- RESP: rsp_valid=1; rsp_data and rsp_err stable until rsp_ready; on handshake → IDLE.
- dsp_* outputs hold their last value in IDLE/RESP; only dsp_start is pulsed.
- proto_err sets when dsp_done=1 in IDLE or RESP.
- No overlap: one operation in flight.

## Timing
- Reset (async assert): state=IDLE, cnt=0. dsp_start=0 and all dsp_* fields=0. rsp_valid=0, rsp_data=0, rsp_err=0, proto_err=0, req_ready=1 after deassert.
- Reset mid-operation aborts silently; no response is produced.
- Request accepted at edge T → ISSUE in cycle T+1 → rsp_valid in cycle T+2+L: mode 00 T+2, mode 01 T+3, mode 10 T+5. Mode 11 → rsp_valid at T+1.
- Errors arrive with the same timing as success.
- After rsp handshake at edge R, req_ready=1 in cycle R+1. Minimum request spacing is 3+L cycles when rsp_ready is held high.
- dsp_done is sampled in the same cycle as dsp_out (DSP result is combinational).

## Test plan
- Mode 00: a=3, b=9'h1FE (low 5 bits = −2), c=10, mac=0; DSP model attached → rsp_valid at T+2, rsp_data=4, rsp_err=0. dsp_start is high only in T+1.
- Mode 10: a=100, b=−3 (9'h1FD), c=0 → rsp_valid at T+5, rsp_data=18'h3FED4 (−300), err=0. dsp_aa/dsp_bb are stable T+1..T+4.
- Mode 11 request → rsp_valid at T+1, rsp_err=1, rsp_data=0; dsp_start never asserts.
- Mode 10 with dsp_done forced 0 → rsp_valid at T+5, rsp_err=1. Forcing dsp_done=1 at cnt=1 instead → rsp_err=1 at T+3.
- Back-pressure: mode 01 with rsp_ready=0 for 5 cycles → rsp_data/rsp_err held and req_ready=0 throughout; handshake → req_ready=1 next cycle. Pulsing dsp_done in IDLE → proto_err=1 until rst_n low.
- Reset asserted in WAIT (mode 10, cnt=2) → immediately IDLE, rsp_valid=0, dsp_start=0, no response after release.
